// File: rtl/tmon_arbiter.sv
// Round-robin arbiter that shares one temperature-monitor command port among NUM_REQ
// masters. The winner's command is latched and issued over valid/ready; a done or err pulse answers it.
package tmon_pkg;
  typedef enum logic [2:0] {
    NOOP          = 3'd0,
    RESET         = 3'd1,
    SET_FRQ       = 3'd2,
    SET_HIGH_TEMP = 3'd3,
    SET_LOW_TEMP  = 3'd4,
    READ_TEMP     = 3'd5
  } tmon_op_t;
endpackage

module tmon_arbiter
  import tmon_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  tmon_op_t           req_op   [NUM_REQ],
  input  logic [7:0]         req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output tmon_op_t           mon_op,
  output logic [7:0]         mon_opnd,
  output logic               mon_valid,
  input  logic               mon_ready,
  output logic               busy
);

  localparam int unsigned   PW       = $clog2(NUM_REQ);
  localparam int unsigned   CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMPLETE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [CW-1:0] count;
  logic          timeout_hit;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first asserted request wins.
  always_comb begin : pick_winner
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[PW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (win_found) state_nxt = (req_op[win_idx] == NOOP) ? S_COMPLETE : S_ISSUE;
      S_ISSUE:
        if (mon_ready)        state_nxt = S_COMPLETE;
        else if (timeout_hit) state_nxt = S_IDLE;
      S_COMPLETE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // done is loaded on the edge entering COMPLETE so it is high exactly during that state;
  // grant is cleared on the same edge so grant, done and err never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      mon_valid <= 1'b0;
      mon_op    <= NOOP;
      mon_opnd  <= '0;
      ptr       <= '0;
      owner     <= '0;
      count     <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner    <= win_idx;
            mon_op   <= req_op[win_idx];
            mon_opnd <= req_data[win_idx];
            count    <= '0;
            if (req_op[win_idx] == NOOP) begin
              done <= onehot(win_idx);
            end else begin
              grant     <= onehot(win_idx);
              mon_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (mon_ready) begin
            mon_valid <= 1'b0;
            grant     <= '0;
            done      <= onehot(owner);
          end else if (timeout_hit) begin
            mon_valid <= 1'b0;
            grant     <= '0;
            err       <= onehot(owner);
            ptr       <= next_idx(owner);
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        S_COMPLETE: begin
          ptr <= next_idx(owner);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmon_arbiter.sv
// Self-checking bench for tmon_arbiter: directed table of round-robin vectors, hand-written
// corner sequences, and a randomized phase checked against a transaction-timeline model.
module tb_tmon_arbiter;
  import tmon_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  tmon_op_t     req_op   [N];
  logic [7:0]   req_data [N];
  logic [N-1:0] grant, done, err;
  tmon_op_t     mon_op;
  logic [7:0]   mon_opnd;
  logic         mon_valid, mon_ready, busy;

  int vectors     = 0;
  int miscompares = 0;

  // Model of the requesters' pending commands and the round-robin pointer.
  logic [N-1:0] m_pend;
  tmon_op_t     m_op  [N];
  logic [7:0]   m_dat [N];
  int           m_rr;

  typedef struct {
    logic [N-1:0] req;
    tmon_op_t     op;
    int           exp_w;
  } rr_vec_t;
  rr_vec_t tbl [12];

  always #5 clk = ~clk;

  tmon_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_data  (req_data),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .mon_op    (mon_op),
    .mon_opnd  (mon_opnd),
    .mon_valid (mon_valid),
    .mon_ready (mon_ready),
    .busy      (busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ed,
                         input logic [N-1:0] ee, input logic ev, input logic eb,
                         input tmon_op_t eop, input logic [7:0] eopnd);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".done"},  32'(done),  32'(ed));
    chk({tag, ".err"},   32'(err),   32'(ee));
    chk({tag, ".valid"}, 32'(mon_valid), 32'(ev));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
    if (ev) begin
      chk({tag, ".op"},   32'(mon_op),   32'(eop));
      chk({tag, ".opnd"}, 32'(mon_opnd), 32'(eopnd));
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++)
      if (r[(p + k) % int'(N)]) return (p + k) % int'(N);
    return -1;
  endfunction

  function automatic tmon_op_t rand_op();
    return tmon_op_t'($urandom_range(0, 5));
  endfunction

  task automatic set_all(input tmon_op_t op, input logic [7:0] d);
    for (int i = 0; i < int'(N); i++) begin
      req_op[i]   = op;
      req_data[i] = d;
    end
  endtask

  task automatic do_reset();
    req       = '0;
    mon_ready = 1'b0;
    #1 reset  = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_out("post_reset", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
  endtask

  task automatic drive_model();
    req = m_pend;
    for (int i = 0; i < int'(N); i++) begin
      req_op[i]   = m_op[i];
      req_data[i] = m_dat[i];
    end
  endtask

  task automatic arrivals();
    for (int i = 0; i < int'(N); i++)
      if (!m_pend[i] && $urandom_range(0, 2) == 0) begin
        m_pend[i] = 1'b1;
        m_op[i]   = rand_op();
        m_dat[i]  = 8'($urandom);
      end
  endtask

  // After done/err a requester either posts a fresh command (req stays high) or drops out.
  task automatic finish_req(input int w);
    if ($urandom_range(0, 1) == 1) begin
      m_op[w]  = rand_op();
      m_dat[w] = 8'($urandom);
    end else begin
      m_pend[w] = 1'b0;
    end
  endtask

  task automatic rand_phase(input int ntx);
    int       w, d;
    tmon_op_t lop;
    logic [7:0] ldat;
    m_pend = '0;
    m_rr   = 0;
    for (int i = 0; i < int'(N); i++) begin
      m_op[i]  = NOOP;
      m_dat[i] = '0;
    end
    for (int t = 0; t < ntx; t++) begin
      arrivals();
      drive_model();
      mon_ready = 1'($urandom);
      step();
      w = pick(m_pend, m_rr);
      if (w < 0) begin
        chk_out("rnd.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
        continue;
      end
      lop  = m_op[w];
      ldat = m_dat[w];
      m_rr = (w + 1) % int'(N);
      if (lop == NOOP) begin
        chk_out("rnd.noop", '0, oh(w), '0, 1'b0, 1'b1, NOOP, 8'h00);
        finish_req(w);
        arrivals();
        drive_model();
        mon_ready = 1'($urandom);
        step();
        chk_out("rnd.after_noop", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
      end else begin
        d = $urandom_range(0, TO + 1);
        for (int c = 0; c < int'(TO); c++) begin
          chk_out("rnd.issue", oh(w), '0, '0, 1'b1, 1'b1, lop, ldat);
          arrivals();
          drive_model();
          if ($urandom_range(0, 1) == 1) begin
            req_op[w]   = rand_op();
            req_data[w] = 8'($urandom);
          end
          if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
          mon_ready = (c == d);
          step();
          if (c == d) break;
        end
        if (d < int'(TO)) begin
          chk_out("rnd.done", '0, oh(w), '0, 1'b0, 1'b1, NOOP, 8'h00);
          finish_req(w);
          arrivals();
          drive_model();
          mon_ready = 1'($urandom);
          step();
          chk_out("rnd.after_done", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
        end else begin
          // The err cycle is already an idle cycle, so the next arbitration starts from it.
          chk_out("rnd.err", '0, '0, oh(w), 1'b0, 1'b0, NOOP, 8'h00);
          finish_req(w);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    tbl[0]  = '{4'b1011, SET_FRQ,       0};
    tbl[1]  = '{4'b1011, SET_HIGH_TEMP, 1};
    tbl[2]  = '{4'b1011, SET_FRQ,       3};
    tbl[3]  = '{4'b1011, RESET,         0};
    tbl[4]  = '{4'b1011, SET_LOW_TEMP,  1};
    tbl[5]  = '{4'b1011, READ_TEMP,     3};
    tbl[6]  = '{4'b0100, SET_FRQ,       2};
    tbl[7]  = '{4'b0111, SET_HIGH_TEMP, 0};
    tbl[8]  = '{4'b1100, SET_FRQ,       2};
    tbl[9]  = '{4'b1100, SET_LOW_TEMP,  3};
    tbl[10] = '{4'b1111, SET_FRQ,       0};
    tbl[11] = '{4'b0001, SET_HIGH_TEMP, 0};

    // Reset held with every requester active.
    reset     = 1'b1;
    req       = '1;
    mon_ready = 1'b0;
    set_all(SET_FRQ, 8'hA5);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("reset", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
      chk("reset.mon_op",   32'(mon_op),   32'(NOOP));
      chk("reset.mon_opnd", 32'(mon_opnd), 32'h0);
    end
    reset = 1'b1;
    req   = '0;
    step();
    chk_out("reset.release", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    // Single request with ready tied high.
    req         = 4'b0100;
    req_op[2]   = SET_FRQ;
    req_data[2] = 8'h3C;
    mon_ready   = 1'b1;
    step();
    chk_out("single.issue", 4'b0100, '0, '0, 1'b1, 1'b1, SET_FRQ, 8'h3C);
    step();
    chk_out("single.done", '0, 4'b0100, '0, 1'b0, 1'b1, NOOP, 8'h00);
    req = '0;
    step();
    chk_out("single.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    // Round-robin vectors from a freshly reset pointer.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      req = tbl[r].req;
      for (int i = 0; i < int'(N); i++) begin
        req_op[i]   = tbl[r].op;
        req_data[i] = 8'(16 * i + r);
      end
      mon_ready = 1'b1;
      step();
      chk_out("rr.issue", oh(tbl[r].exp_w), '0, '0, 1'b1, 1'b1, tbl[r].op,
              8'(16 * tbl[r].exp_w + r));
      step();
      chk_out("rr.done", '0, oh(tbl[r].exp_w), '0, 1'b0, 1'b1, NOOP, 8'h00);
      step();
      chk_out("rr.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
    end

    // Timeout: TO cycles of valid without ready, then err and the pointer moves past the owner.
    do_reset();
    req         = 4'b0010;
    req_op[1]   = SET_LOW_TEMP;
    req_data[1] = 8'h77;
    mon_ready   = 1'b0;
    for (int c = 0; c < int'(TO); c++) begin
      step();
      chk_out("to.issue", 4'b0010, '0, '0, 1'b1, 1'b1, SET_LOW_TEMP, 8'h77);
    end
    step();
    chk_out("to.err", '0, '0, 4'b0010, 1'b0, 1'b0, NOOP, 8'h00);
    req = 4'b1111;
    set_all(SET_FRQ, 8'h21);
    mon_ready = 1'b1;
    step();
    chk_out("to.next_owner", 4'b0100, '0, '0, 1'b1, 1'b1, SET_FRQ, 8'h21);
    step();
    chk_out("to.next_done", '0, 4'b0100, '0, 1'b0, 1'b1, NOOP, 8'h00);
    req = '0;
    step();
    chk_out("to.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    // Ready in the third issue cycle completes normally.
    req         = 4'b0001;
    req_op[0]   = SET_HIGH_TEMP;
    req_data[0] = 8'h11;
    mon_ready   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("late3.issue", 4'b0001, '0, '0, 1'b1, 1'b1, SET_HIGH_TEMP, 8'h11);
      mon_ready = (c == 2);
    end
    step();
    chk_out("late3.done", '0, 4'b0001, '0, 1'b0, 1'b1, NOOP, 8'h00);
    req       = '0;
    mon_ready = 1'b0;
    step();
    chk_out("late3.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    // Ready in the very last cycle before the timeout still wins.
    req         = 4'b1000;
    req_op[3]   = READ_TEMP;
    req_data[3] = 8'hE4;
    for (int c = 0; c < int'(TO); c++) begin
      step();
      chk_out("late4.issue", 4'b1000, '0, '0, 1'b1, 1'b1, READ_TEMP, 8'hE4);
      mon_ready = (c == int'(TO) - 1);
    end
    step();
    chk_out("late4.done", '0, 4'b1000, '0, 1'b0, 1'b1, NOOP, 8'h00);
    req       = '0;
    mon_ready = 1'b0;
    step();
    chk_out("late4.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    // NOOP completes without ever raising mon_valid.
    req         = 4'b0010;
    req_op[1]   = NOOP;
    req_data[1] = 8'h99;
    mon_ready   = 1'b1;
    step();
    chk_out("noop.done", '0, 4'b0010, '0, 1'b0, 1'b1, NOOP, 8'h00);
    req = '0;
    step();
    chk_out("noop.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    // Asynchronous reset in the middle of an issue.
    do_reset();
    req         = 4'b1000;
    req_op[3]   = SET_HIGH_TEMP;
    req_data[3] = 8'h50;
    mon_ready   = 1'b0;
    step();
    chk_out("rstmid.issue0", 4'b1000, '0, '0, 1'b1, 1'b1, SET_HIGH_TEMP, 8'h50);
    step();
    chk_out("rstmid.issue1", 4'b1000, '0, '0, 1'b1, 1'b1, SET_HIGH_TEMP, 8'h50);
    #1 reset = 1'b0;
    #1;
    chk_out("rstmid.async", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
    step();
    chk_out("rstmid.held", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);
    reset = 1'b1;
    req   = 4'b1111;
    set_all(SET_FRQ, 8'h5A);
    mon_ready = 1'b1;
    step();
    chk_out("rstmid.ptr0", 4'b0001, '0, '0, 1'b1, 1'b1, SET_FRQ, 8'h5A);
    step();
    chk_out("rstmid.done", '0, 4'b0001, '0, 1'b0, 1'b1, NOOP, 8'h00);
    req = '0;
    step();
    chk_out("rstmid.idle", '0, '0, '0, 1'b0, 1'b0, NOOP, 8'h00);

    do_reset();
    rand_phase(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
